// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared edge-classification types for the Canny edge path
// Purpose: class and direction encodings plus 3x3 window indexing shared by
// the non-max suppression stage and the later thin-edge stage.
// Ports: none (package).
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE   = 2'd0,
    EDGE_WEAK   = 2'd1,
    EDGE_STRONG = 2'd2
  } edge_class_e;

  // Quantised gradient direction of the centre pixel.
  typedef enum logic [1:0] {
    DIR_H  = 2'd0,
    DIR_D  = 2'd1,
    DIR_AD = 2'd2,
    DIR_V  = 2'd3
  } edge_dir_e;

  localparam int unsigned WIN_N = 3;

  // Flattened window slot for (row, col); slot 0 is top-left, 4 is centre.
  function automatic int unsigned win_idx(input int unsigned row, input int unsigned col);
    return row * WIN_N + col;
  endfunction

endpackage

// File: rtl/nms_neighbor_sel.sv
// rtl/nms_neighbor_sel.sv - direction-driven centre/neighbour mux for a 3x3 window
// Purpose: picks the centre magnitude and the two neighbours lying along the
// gradient direction.
// Ports:
//   window  in  9*MAG_W  flattened 3x3 magnitudes, slot k at [k*MAG_W +: MAG_W]
//   dir     in  2        centre direction (edge_dir_e encoding)
//   center  out MAG_W    slot 4
//   n0, n1  out MAG_W    neighbours along the direction
module nms_neighbor_sel
  import edge_pkg::*;
#(
  parameter int MAG_W = 11
) (
  input  logic [9*MAG_W-1:0] window,
  input  logic [1:0]         dir,
  output logic [MAG_W-1:0]   center,
  output logic [MAG_W-1:0]   n0,
  output logic [MAG_W-1:0]   n1
);

  localparam int unsigned K_TL = win_idx(0, 0);
  localparam int unsigned K_TC = win_idx(0, 1);
  localparam int unsigned K_TR = win_idx(0, 2);
  localparam int unsigned K_ML = win_idx(1, 0);
  localparam int unsigned K_C  = win_idx(1, 1);
  localparam int unsigned K_MR = win_idx(1, 2);
  localparam int unsigned K_BL = win_idx(2, 0);
  localparam int unsigned K_BC = win_idx(2, 1);
  localparam int unsigned K_BR = win_idx(2, 2);

  always_comb begin
    center = window[K_C*MAG_W +: MAG_W];
    n0     = window[K_ML*MAG_W +: MAG_W];
    n1     = window[K_MR*MAG_W +: MAG_W];
    case (edge_dir_e'(dir))
      DIR_D: begin
        n0 = window[K_TL*MAG_W +: MAG_W];
        n1 = window[K_BR*MAG_W +: MAG_W];
      end
      DIR_AD: begin
        n0 = window[K_TR*MAG_W +: MAG_W];
        n1 = window[K_BL*MAG_W +: MAG_W];
      end
      DIR_V: begin
        n0 = window[K_TC*MAG_W +: MAG_W];
        n1 = window[K_BC*MAG_W +: MAG_W];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nms_hysteresis_pipe.sv
// rtl/nms_hysteresis_pipe.sv - pipelined non-max suppression with threshold classification
// Purpose: two-stage pipe. Stage 1 captures the centre and direction neighbours,
// stage 2 suppresses non-maxima and classifies survivors none/weak/strong against
// thresholds latched on each accepted start-of-frame beat. Keeps per-frame
// saturating strong/weak counts of delivered pixels.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_window/in_dir/in_sof  input beat (window, direction, first pixel of frame)
//   in_valid/in_ready        input handshake
//   thr_low/thr_high         thresholds, sampled only on an accepted sof beat
//   out_mag/out_class        centre magnitude (0 if suppressed) and edge class
//   out_dir/out_sof          passthroughs
//   out_valid/out_ready      output handshake
//   strong_cnt/weak_cnt      pixels of each class delivered in the current frame
module nms_hysteresis_pipe
  import edge_pkg::*;
#(
  parameter int               MAG_W      = 11,
  parameter int               CNT_W      = 20,
  parameter bit               STRICT_MAX = 1'b1,
  parameter logic [MAG_W-1:0] LOW_DEF    = MAG_W'(40),
  parameter logic [MAG_W-1:0] HIGH_DEF   = MAG_W'(100)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9*MAG_W-1:0] in_window,
  input  logic [1:0]         in_dir,
  input  logic               in_sof,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAG_W-1:0]   thr_low,
  input  logic [MAG_W-1:0]   thr_high,
  output logic [MAG_W-1:0]   out_mag,
  output logic [1:0]         out_class,
  output logic [1:0]         out_dir,
  output logic               out_sof,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   strong_cnt,
  output logic [CNT_W-1:0]   weak_cnt
);

  // Single enable for the whole pipe: a stalled output freezes both stages.
  logic en;
  logic accept;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  logic [MAG_W-1:0] sel_c, sel_n0, sel_n1;

  nms_neighbor_sel #(.MAG_W(MAG_W)) u_sel (
    .window (in_window),
    .dir    (in_dir),
    .center (sel_c),
    .n0     (sel_n0),
    .n1     (sel_n1)
  );

  logic             s1_valid;
  logic [MAG_W-1:0] s1_c, s1_n0, s1_n1;
  logic [1:0]       s1_dir;
  logic             s1_sof;
  logic [MAG_W-1:0] thr_low_q, thr_high_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_c     <= '0;
      s1_n0    <= '0;
      s1_n1    <= '0;
      s1_dir   <= '0;
      s1_sof   <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_c   <= sel_c;
        s1_n0  <= sel_n0;
        s1_n1  <= sel_n1;
        s1_dir <= in_dir;
        s1_sof <= in_sof;
      end
    end
  end

  // The beat still in stage 1 is classified from the current thresholds at the
  // same edge a new sof overwrites them, so it keeps its own frame's values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_low_q  <= LOW_DEF;
      thr_high_q <= HIGH_DEF;
    end else if (accept && in_sof) begin
      thr_low_q  <= thr_low;
      thr_high_q <= thr_high;
    end
  end

  logic             suppressed;
  logic [MAG_W-1:0] s2_mag;
  edge_class_e      s2_class;

  // Strong is tested first, so low > high simply leaves the weak band empty.
  always_comb begin
    if (STRICT_MAX) suppressed = (s1_c <= s1_n0) || (s1_c <= s1_n1);
    else            suppressed = (s1_c <  s1_n0) || (s1_c <  s1_n1);
    s2_mag   = s1_c;
    s2_class = EDGE_NONE;
    if (suppressed)                s2_mag   = '0;
    else if (s1_c >= thr_high_q)   s2_class = EDGE_STRONG;
    else if (s1_c >= thr_low_q)    s2_class = EDGE_WEAK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_class <= EDGE_NONE;
      out_dir   <= '0;
      out_sof   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mag   <= s2_mag;
        out_class <= s2_class;
        out_dir   <= s1_dir;
        out_sof   <= s1_sof;
      end
    end
  end

  // A delivered sof beat restarts both counts with itself as the first pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strong_cnt <= '0;
      weak_cnt   <= '0;
    end else if (out_valid && out_ready) begin
      if (out_sof) begin
        strong_cnt <= CNT_W'(out_class == EDGE_STRONG);
        weak_cnt   <= CNT_W'(out_class == EDGE_WEAK);
      end else begin
        if (out_class == EDGE_STRONG && strong_cnt != '1) strong_cnt <= strong_cnt + 1'b1;
        if (out_class == EDGE_WEAK && weak_cnt != '1)     weak_cnt   <= weak_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nms_hysteresis_pipe.sv
// tb/tb_nms_hysteresis_pipe.sv - self-checking bench for nms_hysteresis_pipe
module tb_nms_hysteresis_pipe;

  localparam int MW = 11;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [9*MW-1:0] in_window = '0;
  logic [1:0]      in_dir = '0;
  logic            in_sof = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [MW-1:0]   thr_low = '0;
  logic [MW-1:0]   thr_high = '0;

  logic            in_ready_a, in_ready_b;
  logic [MW-1:0]   mag_a, mag_b;
  logic [1:0]      cls_a, cls_b, dir_a, dir_b;
  logic            sof_a, sof_b, ov_a, ov_b;
  logic [19:0]     str_a, wk_a;
  logic [2:0]      str_b, wk_b;

  // Instance a: strict maxima, wide counters. Instance b: non-strict, 3-bit counters.
  nms_hysteresis_pipe #(.MAG_W(MW), .CNT_W(20), .STRICT_MAX(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_window(in_window), .in_dir(in_dir), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready_a), .thr_low(thr_low), .thr_high(thr_high),
    .out_mag(mag_a), .out_class(cls_a), .out_dir(dir_a), .out_sof(sof_a),
    .out_valid(ov_a), .out_ready(out_ready), .strong_cnt(str_a), .weak_cnt(wk_a)
  );

  nms_hysteresis_pipe #(.MAG_W(MW), .CNT_W(3), .STRICT_MAX(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_window(in_window), .in_dir(in_dir), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready_b), .thr_low(thr_low), .thr_high(thr_high),
    .out_mag(mag_b), .out_class(cls_b), .out_dir(dir_b), .out_sof(sof_b),
    .out_valid(ov_b), .out_ready(out_ready), .strong_cnt(str_b), .weak_cnt(wk_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int mag_a; int cls_a; int mag_b; int cls_b; int dir; int sof;
  } exp_t;

  exp_t q[$];
  int   m_lo = 40, m_hi = 100;
  int   m_str[2] = '{0, 0};
  int   m_wk[2]  = '{0, 0};
  int   cmax[2]  = '{1048575, 7};
  int   n_xfer = 0;
  int   nbr0[4] = '{3, 0, 2, 1};
  int   nbr1[4] = '{5, 8, 6, 7};

  function automatic void model_eval(input logic [9*MW-1:0] w, input int d, input bit strict,
                                     input int lo, input int hi, output int mag, output int cls);
    int c, a, b;
    bit supp;
    c = int'(w[4*MW +: MW]);
    a = int'(w[nbr0[d]*MW +: MW]);
    b = int'(w[nbr1[d]*MW +: MW]);
    supp = strict ? (c <= a || c <= b) : (c < a || c < b);
    if (supp) begin
      mag = 0; cls = 0;
    end else begin
      mag = c;
      cls = (c >= hi) ? 2 : (c >= lo) ? 1 : 0;
    end
  endfunction

  function automatic void accept_model(input logic [9*MW-1:0] w, input int d, input bit s,
                                       input int lo, input int hi);
    exp_t e;
    if (s) begin m_lo = lo; m_hi = hi; end
    model_eval(w, d, 1'b1, m_lo, m_hi, e.mag_a, e.cls_a);
    model_eval(w, d, 1'b0, m_lo, m_hi, e.mag_b, e.cls_b);
    e.dir = d;
    e.sof = int'(s);
    q.push_back(e);
  endfunction

  // ---------------- per-cycle compare ----------------
  exp_t ce;
  bit   held = 1'b0;
  logic [MW-1:0] h_mag_a, h_mag_b;
  logic [1:0]    h_cls_a, h_dir_a;
  logic          h_sof_a;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      check("strong_cnt_a", str_a, m_str[0]);
      check("weak_cnt_a", wk_a, m_wk[0]);
      check("strong_cnt_b", str_b, m_str[1]);
      check("weak_cnt_b", wk_b, m_wk[1]);
      check("in_ready_a", in_ready_a, !ov_a || out_ready);
      check("in_ready_b", in_ready_b, !ov_b || out_ready);
      check("valid_b", ov_b, ov_a);
      if (held) begin
        check("hold_valid", ov_a, 1);
        check("hold_mag_a", mag_a, h_mag_a);
        check("hold_mag_b", mag_b, h_mag_b);
        check("hold_class", cls_a, h_cls_a);
        check("hold_dir", dir_a, h_dir_a);
        check("hold_sof", sof_a, h_sof_a);
      end
      if (ov_a) begin
        check("queue_nonempty", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          ce = q[0];
          check("mag_a", mag_a, ce.mag_a);
          check("class_a", cls_a, ce.cls_a);
          check("mag_b", mag_b, ce.mag_b);
          check("class_b", cls_b, ce.cls_b);
          check("dir_a", dir_a, ce.dir);
          check("dir_b", dir_b, ce.dir);
          check("sof_a", sof_a, ce.sof);
          check("sof_b", sof_b, ce.sof);
          if (out_ready) begin
            for (int i = 0; i < 2; i++) begin
              int cl;
              cl = (i == 0) ? ce.cls_a : ce.cls_b;
              if (ce.sof != 0) begin
                m_str[i] = (cl == 2) ? 1 : 0;
                m_wk[i]  = (cl == 1) ? 1 : 0;
              end else begin
                if (cl == 2 && m_str[i] < cmax[i]) m_str[i]++;
                if (cl == 1 && m_wk[i] < cmax[i])  m_wk[i]++;
              end
            end
            void'(q.pop_front());
            n_xfer++;
          end
        end
      end
      held    = ov_a && !out_ready;
      h_mag_a = mag_a;
      h_mag_b = mag_b;
      h_cls_a = cls_a;
      h_dir_a = dir_a;
      h_sof_a = sof_a;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [9*MW-1:0] fill(input int v);
    logic [9*MW-1:0] r;
    for (int k = 0; k < 9; k++) r[k*MW +: MW] = MW'(v);
    return r;
  endfunction

  function automatic logic [9*MW-1:0] setk(input logic [9*MW-1:0] w, input int k, input int v);
    w[k*MW +: MW] = MW'(v);
    return w;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [9*MW-1:0] w, input int d, input bit s, input int lo, input int hi);
    int n = 0;
    in_window = w; in_dir = 2'(d); in_sof = s;
    thr_low = MW'(lo); thr_high = MW'(hi); in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready_a && n < 64);
    check("accept_timeout", in_ready_a, 1);
    if (in_ready_a) accept_model(w, d, s, lo, hi);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input int lat, input int ma, input int ca,
                            input int mb, input int cb);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ov_a && n < 16);
    check({nm, "_latency"}, n, lat);
    check({nm, "_mag_a"}, mag_a, ma);
    check({nm, "_class_a"}, cls_a, ca);
    check({nm, "_mag_b"}, mag_b, mb);
    check({nm, "_class_b"}, cls_b, cb);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check({nm, "_drained"}, q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [9*MW-1:0] w;
    int x0;
    bit  done;

    #1;
    check("rst_valid", ov_a, 0);
    check("rst_mag", mag_a, 0);
    check("rst_class", cls_a, 0);
    check("rst_dir", dir_a, 0);
    check("rst_sof", sof_a, 0);
    check("rst_strong", str_a, 0);
    check("rst_weak", wk_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Horizontal peak
    w = setk(fill(10), 4, 50);
    send(w, 0, 1'b1, 40, 100);
    expect_out("hpeak", 2, 50, 1, 50, 1);

    // Equal neighbour
    w = setk(setk(fill(0), 4, 120), 3, 120);
    send(w, 0, 1'b0, 0, 0);
    expect_out("equal", 2, 0, 0, 120, 2);

    // Direction mux
    w = setk(setk(fill(0), 4, 60), 8, 70);
    send(w, 1, 1'b0, 0, 0);
    expect_out("dir_diag", 2, 0, 0, 0, 0);
    send(w, 3, 1'b0, 0, 0);
    expect_out("dir_vert", 2, 60, 1, 60, 1);

    // Threshold latch
    w = setk(fill(10), 4, 50);
    send(w, 0, 1'b1, 40, 100);
    expect_out("thr_sof", 2, 50, 1, 50, 1);
    w = setk(fill(10), 4, 150);
    send(w, 0, 1'b0, 200, 250);
    expect_out("thr_mid", 2, 150, 2, 150, 2);
    send(w, 0, 1'b1, 200, 250);
    expect_out("thr_new", 2, 150, 0, 150, 0);

    // Counters
    w = setk(fill(10), 4, 150);
    send(w, 0, 1'b1, 40, 100);
    expect_out("cnt0", 2, 150, 2, 150, 2);
    send(w, 0, 1'b0, 40, 100);
    expect_out("cnt1", 2, 150, 2, 150, 2);
    send(w, 0, 1'b0, 40, 100);
    expect_out("cnt2", 2, 150, 2, 150, 2);
    w = setk(fill(10), 4, 50);
    send(w, 0, 1'b0, 40, 100);
    expect_out("cnt3", 2, 50, 1, 50, 1);
    send(w, 0, 1'b0, 40, 100);
    expect_out("cnt4", 2, 50, 1, 50, 1);
    check("cnt_strong_3", str_a, 3);
    check("cnt_weak_2", wk_a, 2);
    w = setk(fill(10), 4, 150);
    send(w, 0, 1'b1, 40, 100);
    expect_out("cnt_sof", 2, 150, 2, 150, 2);
    check("cnt_restart_strong", str_a, 1);
    check("cnt_restart_weak", wk_a, 0);

    // Saturation of the 3-bit counter in instance b
    for (int i = 0; i < 10; i++) send(w, 0, (i == 0), 40, 100);
    drain("sat");
    check("sat_strong_a", str_a, 10);
    check("sat_strong_b", str_b, 7);

    // Backpressure
    x0 = n_xfer;
    fork
      begin
        logic [9*MW-1:0] wb;
        for (int i = 0; i < 5; i++) begin
          wb = setk(fill(0), 4, 50 + 10 * i);
          send(wb, i % 4 == 0 ? 0 : 2, 1'b0, 0, 0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready", in_ready_a, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_delivered", n_xfer - x0, 5);

    // Reset mid-stream
    out_ready = 1'b0;
    w = setk(fill(10), 4, 50);
    send(w, 0, 1'b0, 40, 100);
    send(w, 0, 1'b0, 40, 100);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", ov_a, 0);
    check("mid_rst_strong", str_a, 0);
    check("mid_rst_weak", wk_a, 0);
    q.delete();
    m_lo = 40; m_hi = 100;
    m_str = '{0, 0}; m_wk = '{0, 0};
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(w, 0, 1'b0, 200, 250);
    expect_out("post_rst", 2, 50, 1, 50, 1);

    // Randomised traffic
    done = 1'b0;
    fork
      begin
        logic [9*MW-1:0] wr;
        for (int i = 0; i < 400; i++) begin
          for (int k = 0; k < 9; k++)
            wr[k*MW +: MW] = ($urandom_range(0, 7) == 0) ? MW'($urandom_range(0, 2047))
                                                        : MW'($urandom_range(0, 31));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(wr, int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
               int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/nms_hysteresis_pipe.md
Name: nms_hysteresis_pipe

Overview:
Parametrised, pipelined successor to the combinational non-max suppression stage in the Canny edge path. It takes a 3x3 gradient-magnitude window and the centre pixel's quantised direction. It suppresses non-maxima, then classifies the surviving pixel against frame-latched low/high thresholds as none/weak/strong. It sits between the Sobel/direction stage and the hysteresis tracker, with a valid/ready handshake on both sides and per-frame edge statistics.

Parameters:
MAG_W, 11, gradient magnitude width in bits
CNT_W, 20, width of the per-frame strong/weak edge counters (saturating)
STRICT_MAX, 1, 1: suppress when centre <= a neighbour; 0: suppress only when centre < a neighbour
LOW_DEF, 11'd40, low threshold after reset
HIGH_DEF, 11'd100, high threshold after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_window  in  9*MAG_W  3x3 magnitudes; index k = row*3+col, bits [k*MAG_W +: MAG_W], k=0 top-left, k=4 centre
in_dir  in  2  centre direction: 00 horizontal, 01 diagonal 0/8, 10 anti-diagonal 2/6, 11 vertical
in_sof  in  1  first pixel of frame
in_valid  in  1  input beat valid
in_ready  out  1  stage accepts beat
thr_low  in  MAG_W  low threshold, sampled on accepted sof beat
thr_high  in  MAG_W  high threshold, sampled on accepted sof beat
out_mag  out  MAG_W  centre magnitude, or 0 if suppressed
out_class  out  2  00 none, 01 weak, 10 strong (11 never driven)
out_dir  out  2  direction passthrough
out_sof  out  1  sof passthrough
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
strong_cnt  out  CNT_W  strong pixels output in the current frame
weak_cnt  out  CNT_W  weak pixels output in the current frame

Behaviour:
- Reset (async, active-high): out_valid=0, out_mag=0, out_class=0, out_dir=0, out_sof=0, counters=0, latched thresholds=LOW_DEF/HIGH_DEF, internal valids=0.
- Pipeline: 2 stages; enable en = !out_valid | out_ready; in_ready = en; accept = in_valid & in_ready. Latency is exactly 2 cycles when there is no stall. Order is preserved. No bubbles are inserted while out_ready=1.
- Output stalls: while out_valid & !out_ready, every output is held stable and nothing advances.
- Stage 1, on accept:
  - Register the centre (k=4) and the two direction-selected neighbours: 00 -> k3,k5; 01 -> k0,k8; 10 -> k2,k6; 11 -> k1,k7.
  - Register dir and sof.
  - If in_sof, latch thr_low/thr_high in the same cycle. This beat uses the new thresholds.
- Stage 2:
  - suppressed = (c <= n0 | c <= n1) when STRICT_MAX=1, else (c < n0 | c < n1).
  - If suppressed: out_mag=0, class=none.
  - Else, mag>=high -> strong; else mag>=low -> weak; else none. out_mag=c in all three cases.
  - Comparisons are unsigned.
  - If low > high, the strong test has priority and the weak band is empty.
- Counters update when out_valid & out_ready:
  - If out_sof: load 1 for the matching class and 0 for the other (restart).
  - Else: increment the matching class count, saturating at 2^CNT_W-1.
- Thresholds change only on an accepted sof beat. A mid-frame change on the threshold ports has no effect.
- A reset mid-operation discards all in-flight beats. The first output after reset uses the default thresholds until a sof is accepted.

Decomposition:
- Shared package edge_pkg: class enum (EDGE_NONE=0, EDGE_WEAK=1, EDGE_STRONG=2), direction enum (DIR_H, DIR_D, DIR_AD, DIR_V), and the window index function win_idx(row,col).
- One sub-module, nms_neighbor_sel: a combinational mux from window and dir to the centre and two neighbours, reused by the later thin-edge stage.

Test Plan:
- Horizontal peak: window all 10, k4=50, dir=00, thresholds 40/100 -> 2 cycles later out_mag=50, class=weak, out_valid=1.
- Equal neighbour: k4=120, k3=120, dir=00 -> STRICT_MAX=1 gives mag=0/none; STRICT_MAX=0 gives mag=120/strong.
- Direction mux: k4=60, k8=70, others 0; dir=01 -> suppressed; dir=11 -> mag=60, weak.
- Backpressure: stream 5 beats, hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 5 beats delivered in order with none lost or duplicated.
- Threshold latch: sof beat with thr 40/100, then mid-frame thr 200/250 on a k4=150 peak -> class strong; next sof with 200/250 -> class none.
- Counters and reset: 3 strong + 2 weak beats -> strong_cnt=3, weak_cnt=2. A strong sof beat -> strong_cnt=1, weak_cnt=0. Assert rst mid-stream -> out_valid=0 and counters=0 immediately.
